bist_pattern_ctrl: RTL
======================

// Module: bist_pattern_ctrl
// PURPOSE
// Initiator end of the on-chip BIST interface. On bist_start it takes over the CUT stimulus
// pins (k, j, en) and drives LFSR pseudo-random patterns into them. It compacts the CUT
// responses (synced_d, sync_err_d) into a MISR and compares the final signature with a
// golden value. It then reports bist_end and pass_fail to the top level.
// PARAMETERS
// LFSR_W     8       pattern LFSR width (>=3)
// LFSR_SEED  8'hA5   LFSR load value; 0 is replaced by 1
// LFSR_TAPS  8'hB8   LFSR feedback tap mask (Fibonacci)
// MISR_W     8       signature width (>=2)
// MISR_TAPS  8'hB8   MISR feedback tap mask
// N_PAT      200     patterns applied per run (1..2^CNT_W-1-PIPE_D)
// PIPE_D     1       CUT stimulus->response latency in clocks (0..3)
// CNT_W      10      pattern counter width
// GOLDEN     8'h00   expected signature; set per CUT from the reference model
// PORTS
// CLK            in   1       clock, rising edge
// RST            in   1       asynchronous reset, active LOW
// bist_start     in   1       level request; rising edge starts a run; low aborts or rearms
// cut_synced_d   in   1       CUT response bit 0
// cut_sync_err_d in   1       CUT response bit 1
// bist_mode      out  1       1 = CUT inputs are muxed to test_k/test_j/test_en
// test_k         out  1       pattern bit, = lfsr[0]
// test_j         out  1       pattern bit, = lfsr[1]
// test_en        out  1       pattern bit, = lfsr[2]
// signature      out  MISR_W  live MISR contents
// bist_end       out  1       run complete; held high in DONE
// pass_fail      out  1       1 = signature==GOLDEN; valid only while bist_end=1
// BEHAVIOUR
// - RST low (async): state=IDLE, lfsr=LFSR_SEED, misr=0, cnt=0, all outputs 0.
// - Registered start edge: start_q<=bist_start. go = bist_start & ~start_q.
// - FSM, all transitions on the CLK rising edge:
//   IDLE    -> INIT when go.
//   INIT    (1 clk): load lfsr, clear misr and cnt, bist_mode=1 -> RUN.
//   RUN     (N_PAT+PIPE_D clks): lfsr steps while cnt<N_PAT and holds afterwards.
//           misr updates only while cnt>=PIPE_D. cnt+1 every clk.
//           At cnt==N_PAT+PIPE_D-1 -> CMP.
//   CMP     (1 clk): pass_fail<=(misr==GOLDEN) -> DONE.
//   DONE:   bist_end=1, bist_mode=0, pass_fail and signature frozen.
//           -> IDLE when bist_start==0; that clears bist_end and pass_fail.
// - Abort: bist_start==0 in INIT/RUN/CMP -> IDLE next edge. On abort, bist_mode=0,
//   bist_end stays 0 and the signature is discarded.
// - LFSR: fb=^(lfsr&LFSR_TAPS); lfsr<={lfsr[LFSR_W-2:0],fb}. Never all-zero.
// - MISR: misr<={misr[MISR_W-2:0],^(misr&MISR_TAPS)} ^ {0..,cut_sync_err_d,cut_synced_d}.
// - test_k/j/en are 0 outside RUN. First pattern (=LFSR_SEED bits) appears in the first RUN clk.
// - bist_end rises exactly N_PAT+PIPE_D+2 clks after the edge that samples go
//   (203 with the defaults).
// - A new go while in DONE is ignored; bist_start must return low first.
// TESTING
// 1 Hold RST=0 with no clock -> bist_mode/test_*/bist_end/pass_fail=0, signature=0.
// 2 bist_start 0->1 at edge E (defaults) -> bist_mode=1 after E+1; test_k/j/en = 1/0/1
//   (seed A5) after E+1; bist_end=1 after E+203.
// 3 Behavioural CUT model, GOLDEN = model signature -> bist_end=1 and pass_fail=1.
//   signature == GOLDEN.
// 4 Same run, flip cut_sync_err_d for one clk at pattern 57 -> bist_end=1, pass_fail=0.
// 5 Drop bist_start at RUN pattern 20 -> IDLE next edge, bist_end never rises.
//   Restart -> signature identical to scenario 3.
// 6 LFSR_SEED=0, N_PAT=255, responses tied 0 -> test pattern never 3'b000 with lfsr==0.
//   Async RST pulse mid-RUN clears all outputs without a clock edge.

Source files
------------

// File: rtl/bist_pattern_ctrl_if.sv
// rtl/bist_pattern_ctrl_if.sv - BIST initiator control, CUT stimulus and CUT response bundle
//
// Signals:
//   bist_start      level request from the top level (rising edge starts a run)
//   cut_synced_d    CUT response bit 0
//   cut_sync_err_d  CUT response bit 1
//   bist_mode       1 = CUT inputs are taken from test_k/test_j/test_en
//   test_k/j/en     pattern bits applied to the CUT
//   signature       live MISR contents
//   bist_end        run complete
//   pass_fail       1 = signature matched the golden value (valid with bist_end)
//
// master: the BIST controller.  slave: the top level / CUT side.
interface bist_pattern_ctrl_if #(
    parameter int MISR_W = 8
);
    logic              bist_start;
    logic              cut_synced_d;
    logic              cut_sync_err_d;
    logic              bist_mode;
    logic              test_k;
    logic              test_j;
    logic              test_en;
    logic [MISR_W-1:0] signature;
    logic              bist_end;
    logic              pass_fail;

    modport master (
        input  bist_start,
        input  cut_synced_d,
        input  cut_sync_err_d,
        output bist_mode,
        output test_k,
        output test_j,
        output test_en,
        output signature,
        output bist_end,
        output pass_fail
    );

    modport slave (
        output bist_start,
        output cut_synced_d,
        output cut_sync_err_d,
        input  bist_mode,
        input  test_k,
        input  test_j,
        input  test_en,
        input  signature,
        input  bist_end,
        input  pass_fail
    );
endinterface

// File: rtl/bist_pattern_ctrl.sv
// rtl/bist_pattern_ctrl.sv - BIST initiator: LFSR pattern generation, MISR compaction, golden compare
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous reset, active low
//   bus    master modport of bist_pattern_ctrl_if (start request, CUT responses,
//          CUT stimulus, signature, bist_end, pass_fail)
//
// Run sequence: IDLE -> INIT (1 clk) -> RUN (N_PAT+PIPE_D clks) -> CMP (1 clk) -> DONE.
// Dropping bist_start in INIT/RUN/CMP aborts to IDLE; dropping it in DONE rearms.
module bist_pattern_ctrl #(
    parameter int                 LFSR_W    = 8,
    parameter logic [LFSR_W-1:0]  LFSR_SEED = 8'hA5,
    parameter logic [LFSR_W-1:0]  LFSR_TAPS = 8'hB8,
    parameter int                 MISR_W    = 8,
    parameter logic [MISR_W-1:0]  MISR_TAPS = 8'hB8,
    parameter int                 N_PAT     = 200,
    parameter int                 PIPE_D    = 1,
    parameter int                 CNT_W     = 10,
    parameter logic [MISR_W-1:0]  GOLDEN    = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    bist_pattern_ctrl_if.master bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    localparam logic [CNT_W-1:0] N_PAT_C  = CNT_W'(N_PAT);
    localparam logic [CNT_W-1:0] PIPE_C   = CNT_W'(PIPE_D);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PAT + PIPE_D - 1);

    logic [2:0]        state;
    logic              start_q;
    logic [LFSR_W-1:0] lfsr;
    logic [MISR_W-1:0] misr;
    logic [CNT_W-1:0]  cnt;
    logic              bist_mode_r;
    logic              bist_end_r;
    logic              pass_fail_r;

    logic              go;
    logic              abort;
    logic              run_st;
    logic [LFSR_W-1:0] lfsr_next;
    logic [MISR_W-1:0] misr_next;

    assign go     = bus.bist_start & ~start_q;
    assign run_st = (state == S_RUN);

    // Releasing the request while a run is still in flight abandons it.
    assign abort  = ~bus.bist_start &
                    ((state == S_INIT) | (state == S_RUN) | (state == S_CMP));

    // Fibonacci LFSR: shift left, parity of the tapped bits enters at bit 0.
    assign lfsr_next = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};

    // MISR: same shift structure, the two response bits folded into the low bits.
    assign misr_next = {misr[MISR_W-2:0], ^(misr & MISR_TAPS)}
                     ^ MISR_W'({bus.cut_sync_err_d, bus.cut_synced_d});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            start_q     <= 1'b0;
            lfsr        <= SEED_EFF;
            misr        <= '0;
            cnt         <= '0;
            bist_mode_r <= 1'b0;
            bist_end_r  <= 1'b0;
            pass_fail_r <= 1'b0;
        end else begin
            start_q <= bus.bist_start;

            if (abort) begin
                // Partial signature is meaningless; drop it and hand the pins back.
                state       <= S_IDLE;
                bist_mode_r <= 1'b0;
                bist_end_r  <= 1'b0;
                pass_fail_r <= 1'b0;
                misr        <= '0;
                cnt         <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (go) begin
                            state <= S_INIT;
                        end
                    end

                    S_INIT: begin
                        lfsr        <= SEED_EFF;
                        misr        <= '0;
                        cnt         <= '0;
                        bist_mode_r <= 1'b1;
                        state       <= S_RUN;
                    end

                    S_RUN: begin
                        // Patterns stop after N_PAT; the extra PIPE_D clocks only
                        // drain the CUT responses still in its pipeline.
                        if (cnt < N_PAT_C) begin
                            lfsr <= lfsr_next;
                        end
                        // The first PIPE_D response cycles carry no pattern yet.
                        if (cnt >= PIPE_C) begin
                            misr <= misr_next;
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            state <= S_CMP;
                        end
                    end

                    S_CMP: begin
                        pass_fail_r <= (misr == GOLDEN);
                        bist_end_r  <= 1'b1;
                        bist_mode_r <= 1'b0;
                        state       <= S_DONE;
                    end

                    S_DONE: begin
                        // Hold the result until the requester lets go; a new run
                        // needs a fresh rising edge after that.
                        if (!bus.bist_start) begin
                            state       <= S_IDLE;
                            bist_end_r  <= 1'b0;
                            pass_fail_r <= 1'b0;
                        end
                    end

                    default: begin
                        state       <= S_IDLE;
                        bist_mode_r <= 1'b0;
                        bist_end_r  <= 1'b0;
                        pass_fail_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Stimulus is only driven while patterns are being applied.
    assign bus.test_k    = run_st & lfsr[0];
    assign bus.test_j    = run_st & lfsr[1];
    assign bus.test_en   = run_st & lfsr[2];

    assign bus.bist_mode = bist_mode_r;
    assign bus.signature = misr;
    assign bus.bist_end  = bist_end_r;
    assign bus.pass_fail = pass_fail_r;

endmodule
